// File: rtl/ro_meter_pkg.sv
// Shared types and default sizing for the ring-oscillator frequency meter.
package ro_meter_pkg;

  localparam int unsigned DefNumCh = 4;
  localparam int unsigned DefCntW  = 32;
  localparam int unsigned DefWinW  = 16;

  typedef enum logic [1:0] {
    StIdle,
    StGate,
    StDone
  } state_e;

endpackage

// File: rtl/ro_edge_counter.sv
// One meter channel: synchroniser, rising-edge detector and saturating edge counter.
module ro_edge_counter import ro_meter_pkg::*; #(
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_signal,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  logic [1:0]       sync_q, sync_d;
  logic             hist_q, hist_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             edge_det;

  assign edge_det = sync_q[1] & ~hist_q;

  always_comb begin
    sync_d = {sync_q[0], in_signal};
    hist_d = sync_q[1];
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    if (clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (en && edge_det) begin
      // Saturate instead of wrapping; the flag stays set until the next clear.
      if (cnt_q == {CNT_W{1'b1}}) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/ro_freq_meter.sv
// Multi-channel gated edge counter: counts input edges over a programmable window of clk cycles.
module ro_freq_meter import ro_meter_pkg::*; #(
  parameter int unsigned NUM_CH = DefNumCh,
  parameter int unsigned CNT_W  = DefCntW,
  parameter int unsigned WIN_W  = DefWinW
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       in_signal,
  input  logic                    start,
  input  logic                    continuous,
  input  logic [WIN_W-1:0]        window_len,
  input  logic                    pause,
  output logic [NUM_CH*CNT_W-1:0] freq,
  output logic [NUM_CH-1:0]       overflow,
  output logic                    valid,
  output logic                    busy
);

  state_e                  state_q, state_d;
  logic [WIN_W-1:0]        win_len_q, win_len_d;
  logic [WIN_W-1:0]        win_cnt_q, win_cnt_d;
  logic [NUM_CH*CNT_W-1:0] freq_q, freq_d;
  logic [NUM_CH-1:0]       ovf_q, ovf_d;
  logic                    valid_q, valid_d;

  logic                    cnt_clr;
  logic                    cnt_en;
  logic                    latch;
  logic [NUM_CH*CNT_W-1:0] cnt_all;
  logic [NUM_CH-1:0]       ovf_all;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ro_edge_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .in_signal(in_signal[g]),
      .clr      (cnt_clr),
      .en       (cnt_en),
      .cnt      (cnt_all[g*CNT_W +: CNT_W]),
      .ovf      (ovf_all[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      win_len_q <= '0;
      win_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      win_len_q <= win_len_d;
      win_cnt_q <= win_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    win_len_d = win_len_q;
    win_cnt_d = win_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          // A zero-length window would never terminate; run it as one cycle.
          win_len_d = (window_len == '0) ? WIN_W'(1) : window_len;
          win_cnt_d = win_len_d;
          state_d   = StGate;
        end
      end
      StGate: begin
        if (!pause) begin
          win_cnt_d = win_cnt_q - 1'b1;
          if (win_cnt_q == WIN_W'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (continuous) begin
          win_cnt_d = win_len_q;
          state_d   = StGate;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_clr = ((state_q == StIdle) && start) || (state_q == StDone);
    cnt_en  = (state_q == StGate) && !pause;
    latch   = (state_q == StDone);
    busy    = (state_q != StIdle);
    freq_d  = latch ? cnt_all : freq_q;
    ovf_d   = latch ? ovf_all : ovf_q;
    valid_d = latch;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      freq_q  <= '0;
      ovf_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      freq_q  <= freq_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign freq     = freq_q;
  assign overflow = ovf_q;
  assign valid    = valid_q;

endmodule

// File: tb/tb_ro_freq_meter.sv
// Scoreboard bench: a 32-bit and a 4-bit counter build share stimulus; a monitor checks each valid.
module tb_ro_freq_meter;

  typedef struct packed {
    logic [31:0]      cyc;
    logic [3:0][31:0] lo;
    logic [3:0][31:0] hi;
    logic [3:0]       ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic        pause = 1'b0;
  logic [15:0] window_len = 16'd0;
  logic        ch0 = 1'b0, ch1 = 1'b0, ch2 = 1'b0;
  logic [3:0]  in_sig;

  logic [127:0]     freq_b;
  logic [15:0]      freq_s;
  logic [3:0]       ovf_b, ovf_s;
  logic             valid_b, valid_s, busy_b, busy_s;
  logic [3:0][31:0] f_b, f_s;

  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_err = 0;
  exp_t q_b[$];
  exp_t q_s[$];

  assign in_sig = {1'b0, ch2, ch1, ch0};
  assign f_b = freq_b;
  always_comb begin
    for (int i = 0; i < 4; i++) f_s[i] = 32'(freq_s[i*4 +: 4]);
  end

  ro_freq_meter #(.NUM_CH(4), .CNT_W(32), .WIN_W(16)) dut (
    .clk(clk), .reset(reset), .in_signal(in_sig), .start(start), .continuous(continuous),
    .window_len(window_len), .pause(pause), .freq(freq_b), .overflow(ovf_b),
    .valid(valid_b), .busy(busy_b)
  );

  ro_freq_meter #(.NUM_CH(4), .CNT_W(4), .WIN_W(16)) dut_s (
    .clk(clk), .reset(reset), .in_signal(in_sig), .start(start), .continuous(continuous),
    .window_len(window_len), .pause(pause), .freq(freq_s), .overflow(ovf_s),
    .valid(valid_s), .busy(busy_s)
  );

  // 100 MHz clock; channel periods 40/80/160 ns, offset from clock edges
  always #5 clk = ~clk;
  initial begin #3; forever #20 ch0 = ~ch0; end
  initial begin #3; forever #40 ch1 = ~ch1; end
  initial begin #3; forever #80 ch2 = ~ch2; end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string name, input int unsigned act, input int unsigned lo,
                     input int unsigned hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    end
  endtask

  task automatic check_out(input string who, input exp_t e, input logic [3:0][31:0] f,
                           input logic [3:0] ov);
    cmp({who, "_valid_cycle"}, cyc, e.cyc, e.cyc);
    for (int i = 0; i < 4; i++) begin
      cmp($sformatf("%s_freq_ch%0d", who, i), f[i], e.lo[i], e.hi[i]);
    end
    cmp({who, "_overflow"}, 32'(ov), 32'(e.ovf), 32'(e.ovf));
  endtask

  always @(negedge clk) begin
    if (valid_b) begin
      if (q_b.size() == 0) cmp("big_unexpected_valid", 1, 0, 0);
      else check_out("big", q_b.pop_front(), f_b, ovf_b);
    end
    if (valid_s) begin
      if (q_s.size() == 0) cmp("small_unexpected_valid", 1, 0, 0);
      else check_out("small", q_s.pop_front(), f_s, ovf_s);
    end
  end

  function automatic logic [3:0][31:0] pk(input int unsigned a0, input int unsigned a1,
                                          input int unsigned a2, input int unsigned a3);
    logic [3:0][31:0] r;
    r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
    return r;
  endfunction

  // Small build expectations clip to 15; its overflow flags are given explicitly.
  task automatic push(input int unsigned c, input logic [3:0][31:0] lo,
                      input logic [3:0][31:0] hi, input logic [3:0] ov_s);
    exp_t eb, es;
    eb.cyc = c; eb.lo = lo; eb.hi = hi; eb.ovf = 4'b0000;
    es = eb;
    es.ovf = ov_s;
    for (int i = 0; i < 4; i++) begin
      es.lo[i] = (lo[i] > 15) ? 32'd15 : lo[i];
      es.hi[i] = (hi[i] > 15) ? 32'd15 : hi[i];
    end
    q_b.push_back(eb);
    q_s.push_back(es);
  endtask

  task automatic start_meas(input logic [15:0] win, input logic cont, output int unsigned s);
    window_len = win;
    continuous = cont;
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input int unsigned max_cyc);
    int unsigned k = 0;
    while ((q_b.size() != 0 || q_s.size() != 0) && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    cmp("drain_pending", q_b.size() + q_s.size(), 0, 0);
  endtask

  task automatic check_idle(input string tag);
    cmp({tag, "_busy_big"}, 32'(busy_b), 0, 0);
    cmp({tag, "_busy_small"}, 32'(busy_s), 0, 0);
    cmp({tag, "_valid_big"}, 32'(valid_b), 0, 0);
    cmp({tag, "_freq0_big"}, f_b[0], 0, 0);
    cmp({tag, "_freq0_small"}, f_s[0], 0, 0);
    cmp({tag, "_ovf_small"}, 32'(ovf_s), 0, 0);
  endtask

  initial begin
    int unsigned s;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_idle("reset");

    // Basic window of 100; a late start/window_len change must be ignored.
    start_meas(16'd100, 1'b0, s);
    push(s + 102, pk(24, 12, 6, 0), pk(26, 13, 7, 0), 4'b0001);
    repeat (20) @(negedge clk);
    window_len = 16'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain(200);
    repeat (10) @(negedge clk);
    cmp("hold_freq0_big", f_b[0], 24, 26);
    cmp("hold_ovf_small", 32'(ovf_s), 1, 1);

    // Zero-length window runs as one cycle.
    start_meas(16'd0, 1'b0, s);
    push(s + 3, pk(0, 0, 0, 0), pk(1, 1, 1, 0), 4'b0000);
    wait_drain(20);

    // Pause for 20 cycles mid-window.
    start_meas(16'd100, 1'b0, s);
    push(s + 122, pk(24, 11, 5, 0), pk(26, 14, 8, 0), 4'b0001);
    repeat (30) @(negedge clk);
    pause = 1'b1;
    repeat (20) @(negedge clk);
    pause = 1'b0;
    wait_drain(200);

    // Continuous mode, then drop continuous during the third window.
    start_meas(16'd50, 1'b1, s);
    for (int k = 0; k < 3; k++) begin
      push(s + 52 + 51 * k, pk(12, 6, 3, 0), pk(13, 7, 4, 0), 4'b0000);
    end
    while (cyc < s + 110) @(negedge clk);
    continuous = 1'b0;
    wait_drain(200);
    repeat (5) @(negedge clk);
    cmp("cont_end_busy_big", 32'(busy_b), 0, 0);
    cmp("cont_end_busy_small", 32'(busy_s), 0, 0);
    repeat (60) @(negedge clk);

    // Reset mid-gate: no result, outputs cleared.
    start_meas(16'd100, 1'b0, s);
    repeat (30) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle("midreset");
    repeat (120) @(negedge clk);

    // All four channels, window 160.
    start_meas(16'd160, 1'b0, s);
    push(s + 162, pk(39, 19, 9, 0), pk(41, 21, 11, 0), 4'b0011);
    wait_drain(300);
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
